// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: one outstanding load/store,
// fixed-latency response, RV32I sizing with fault reporting.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic          a_we;
    logic [31:0]   a_addr;
    logic [2:0]    a_f3;
    logic [31:0]   a_wdata;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   word;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic          oor;
    logic          err;
    logic [3:0]    be;
    logic [31:0]   mask;
    logic [31:0]   wword;
    logic [31:0]   merged;
    logic [31:0]   ldata;
    logic          commit;

    assign req_ready = (state == IDLE) && !reset;
    assign commit    = (state == WAIT) && (cnt == '0);

    assign idx  = a_addr[AW+1:2];
    assign lane = a_addr[1:0];
    assign word = mem[idx];
    assign oor  = a_addr[31:2] >= 30'(DEPTH_WORDS);

    always_comb begin
        bsel = word[7:0];
        unique case (lane)
            2'd0:    bsel = word[7:0];
            2'd1:    bsel = word[15:8];
            2'd2:    bsel = word[23:16];
            default: bsel = word[31:24];
        endcase
        hsel = lane[1] ? word[31:16] : word[15:0];
    end

    // Decode size, lanes and faults from the latched request.
    always_comb begin
        err   = 1'b0;
        be    = 4'b0000;
        wword = 32'h0;
        ldata = 32'h0;
        unique case (a_f3)
            3'd0: begin
                be    = 4'b0001 << lane;
                wword = {4{a_wdata[7:0]}};
                ldata = {{24{bsel[7]}}, bsel};
            end
            3'd1: begin
                err   = lane[0];
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{a_wdata[15:0]}};
                ldata = {{16{hsel[15]}}, hsel};
            end
            3'd2: begin
                err   = |lane;
                be    = 4'b1111;
                wword = a_wdata;
                ldata = word;
            end
            3'd4: begin
                err   = a_we;
                ldata = {24'h0, bsel};
            end
            3'd5: begin
                err   = a_we | lane[0];
                ldata = {16'h0, hsel};
            end
            default: begin
                err = 1'b1;
            end
        endcase
        err = err | oor;
    end

    assign mask = {{8{be[3]}}, {8{be[2]}},
                   {8{be[1]}}, {8{be[0]}}};
    assign merged = (word & ~mask) | (wword & mask);

    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            a_we    <= req_we;
            a_addr  <= req_addr;
            a_f3    <= req_funct3;
            a_wdata <= req_wdata;
        end
    end

    // Not reset: contents survive, and a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (!reset && commit && a_we && !err) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        cnt   <= CW'(LATENCY - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (err || a_we) ? 32'h0 : ldata;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 1 and 4)
// checked every cycle against a byte-addressed timestamp model.
module tb_data_mem_responder;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        rv   [2];
    logic        rdy  [2];
    logic        rwe  [2];
    logic [31:0] ra   [2];
    logic [2:0]  rf   [2];
    logic [31:0] rwd  [2];
    logic        vld  [2];
    logic        rr   [2];
    logic [31:0] rdat [2];
    logic        rerr [2];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(rst[0]),
        .req_valid(rv[0]), .req_ready(rdy[0]),
        .req_we(rwe[0]), .req_addr(ra[0]),
        .req_funct3(rf[0]), .req_wdata(rwd[0]),
        .rsp_valid(vld[0]), .rsp_ready(rr[0]),
        .rsp_rdata(rdat[0]), .rsp_err(rerr[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(rst[1]),
        .req_valid(rv[1]), .req_ready(rdy[1]),
        .req_we(rwe[1]), .req_addr(ra[1]),
        .req_funct3(rf[1]), .req_wdata(rwd[1]),
        .rsp_valid(vld[1]), .rsp_ready(rr[1]),
        .rsp_rdata(rdat[1]), .rsp_err(rerr[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: byte memory, outstanding request and its due cycle.
    logic [7:0]  mb    [2][4*DEPTH];
    int          cyc   = 0;
    bit          pend  [2] = '{0, 0};
    int          due   [2] = '{0, 0};
    logic        q_we  [2];
    logic [31:0] q_a   [2];
    logic [2:0]  q_f3  [2];
    logic [31:0] q_wd  [2];
    logic [31:0] sh_rd [2] = '{0, 0};
    logic        sh_er [2] = '{0, 0};

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string nm, input int k,
                       input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s inst=%0d t=%0t got=%h want=%h",
                     nm, k, $time, got, want);
        end
    endtask

    function automatic void access(input int k,
                                   output logic [31:0] rd,
                                   output logic er);
        logic [31:0] a;
        logic [31:0] v;
        int sz;
        a = q_a[k];
        case (q_f3[k][1:0])
            2'd0:    sz = 1;
            2'd1:    sz = 2;
            default: sz = 4;
        endcase
        er = (q_f3[k] == 3'd3) || (q_f3[k] >= 3'd6) ||
             (q_we[k] && q_f3[k] >= 3'd4) ||
             ((a >> 2) >= 32'(DEPTH)) ||
             ((a & 32'(sz - 1)) != 0);
        rd = 32'h0;
        if (!er) begin
            if (q_we[k]) begin
                for (int i = 0; i < sz; i++)
                    mb[k][int'(a) + i] = q_wd[k][8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < sz; i++)
                    v = v | (32'(mb[k][int'(a) + i]) << (8 * i));
                if (q_f3[k] < 3'd4 && sz < 4 && v[8*sz-1])
                    v = v | (32'hFFFF_FFFF << (8 * sz));
                rd = v;
            end
        end
    endfunction

    // Model update on every edge, from pre-edge inputs.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                bit vpre;
                logic [31:0] d;
                logic e;
                vpre = pend[k] && (cyc - 1) >= due[k];
                if (rst[k]) begin
                    pend[k]  = 0;
                    sh_rd[k] = 32'h0;
                    sh_er[k] = 1'b0;
                end else if (vpre && rr[k]) begin
                    pend[k] = 0;
                end else if (pend[k] && cyc == due[k]) begin
                    access(k, d, e);
                    sh_rd[k] = d;
                    sh_er[k] = e;
                end else if (!pend[k] && rv[k]) begin
                    pend[k] = 1;
                    due[k]  = cyc + lat_of(k);
                    q_we[k] = rwe[k];
                    q_a[k]  = ra[k];
                    q_f3[k] = rf[k];
                    q_wd[k] = rwd[k];
                end
            end
        end
    end

    // Every-cycle compare on the falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                bit ev;
                ev = pend[k] && cyc >= due[k];
                chk("req_ready", k, 32'(rdy[k]),
                    32'(!pend[k] && !rst[k]));
                chk("rsp_valid", k, 32'(vld[k]), 32'(ev));
                chk("rsp_rdata", k, rdat[k], sh_rd[k]);
                chk("rsp_err", k, 32'(rerr[k]), 32'(sh_er[k]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input int k, input logic we,
                        input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er,
                        output int lat);
        int t;
        rd = 32'h0;
        er = 1'b0;
        lat = 0;
        rv[k]  = 1'b1;
        rwe[k] = we;
        ra[k]  = a;
        rf[k]  = f3;
        rwd[k] = wd;
        t = 0;
        while (!rdy[k] && t < 50) begin
            step();
            t++;
        end
        if (!rdy[k]) begin
            chk("accept_timeout", k, 32'(rdy[k]), 32'd1);
            rv[k] = 1'b0;
            return;
        end
        step();
        rv[k]  = 1'b0;
        rwe[k] = 1'($urandom_range(0, 1));
        ra[k]  = $urandom;
        rf[k]  = 3'($urandom_range(0, 7));
        rwd[k] = $urandom;
        while (!vld[k] && lat < 40) begin
            rr[k] = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        if (!vld[k]) begin
            chk("rsp_timeout", k, 32'(vld[k]), 32'd1);
            rr[k] = 1'b0;
            return;
        end
        rd = rdat[k];
        er = rerr[k];
        for (int h = 0; h < hold; h++) begin
            rr[k] = 1'b0;
            rv[k] = 1'($urandom_range(0, 1));
            ra[k] = $urandom_range(0, 4 * DEPTH - 1);
            step();
            if (hold >= 10) chk("bp_req_ready", k, 32'(rdy[k]), 0);
        end
        rv[k] = 1'b0;
        rr[k] = 1'b1;
        step();
        rr[k] = 1'b0;
    endtask

    logic [31:0] ea  [5] = '{32'h11, 32'h13, 32'(4 * DEPTH),
                             32'h50, 32'h50};
    logic        ewe [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  ef3 [5] = '{3'd2, 3'd1, 3'd2, 3'd4, 3'd3};
    logic [2:0]  lld [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        logic [31:0] d;
        logic e;
        int l;
        bit seen;

        #1_000_000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] d;
        logic e;
        int l;
        bit seen;
        logic we;
        logic [2:0] f3;
        logic [31:0] a;

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            rv[k]  = 1'b0;
            rwe[k] = 1'b0;
            ra[k]  = 32'h0;
            rf[k]  = 3'd0;
            rwd[k] = 32'h0;
            rr[k]  = 1'b0;
        end
        repeat (3) step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", k, 32'(rdy[k]), 32'd1);
            chk("rst_rsp_valid", k, 32'(vld[k]), 0);
            chk("rst_rsp_rdata", k, rdat[k], 0);
            chk("rst_rsp_err", k, 32'(rerr[k]), 0);
        end

        for (int k = 0; k < 2; k++)
            for (int w = 0; w < DEPTH; w++)
                xact(k, 1'b1, 32'(4 * w), 3'd2, $urandom, 0, d, e, l);

        xact(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 0, d, e, l);
        chk("sw10_err", 0, 32'(e), 0);
        chk("sw10_rdata", 0, d, 0);
        chk("sw10_lat", 0, 32'(l), 32'd1);
        xact(0, 1'b0, 32'h10, 3'd2, 32'h0, 0, d, e, l);
        chk("lw10", 0, d, 32'hDEADBEEF);

        xact(0, 1'b1, 32'h20, 3'd2, 32'h80F07F81, 0, d, e, l);
        xact(0, 1'b0, 32'h20, 3'd0, 32'h0, 0, d, e, l);
        chk("lb20", 0, d, 32'hFFFFFF81);
        xact(0, 1'b0, 32'h23, 3'd4, 32'h0, 1, d, e, l);
        chk("lbu23", 0, d, 32'h00000080);
        xact(0, 1'b0, 32'h22, 3'd1, 32'h0, 0, d, e, l);
        chk("lh22", 0, d, 32'hFFFF80F0);
        xact(0, 1'b0, 32'h20, 3'd5, 32'h0, 2, d, e, l);
        chk("lhu20", 0, d, 32'h00007F81);

        xact(0, 1'b1, 32'h30, 3'd2, 32'h11223344, 0, d, e, l);
        xact(0, 1'b1, 32'h31, 3'd0, 32'h555555AA, 0, d, e, l);
        xact(0, 1'b1, 32'h32, 3'd1, 32'h7777BEEF, 0, d, e, l);
        xact(0, 1'b0, 32'h30, 3'd2, 32'h0, 0, d, e, l);
        chk("lw30_lanes", 0, d, 32'hBEEFAA44);

        for (int i = 0; i < 5; i++) begin
            xact(0, ewe[i], ea[i], ef3[i], 32'h5A5A5A5A, 0, d, e, l);
            chk("err_flag", 0, 32'(e), 32'd1);
            chk("err_rdata", 0, d, 0);
        end
        xact(0, 1'b0, 32'h10, 3'd2, 32'h0, 0, d, e, l);
        chk("lw10_after_err", 0, d, 32'hDEADBEEF);

        xact(1, 1'b1, 32'h40, 3'd2, 32'hCAFEF00D, 0, d, e, l);
        xact(1, 1'b0, 32'h40, 3'd2, 32'h0, 10, d, e, l);
        chk("bp_lat", 1, 32'(l), 32'd4);
        chk("bp_rdata", 1, d, 32'hCAFEF00D);
        chk("bp_ready_after", 1, 32'(rdy[1]), 32'd1);

        rv[1]  = 1'b1;
        rwe[1] = 1'b1;
        ra[1]  = 32'h40;
        rf[1]  = 3'd2;
        rwd[1] = 32'h12345678;
        step();
        rv[1] = 1'b0;
        step();
        step();
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        #1;
        chk("ready_after_rst", 1, 32'(rdy[1]), 32'd1);
        seen = 0;
        repeat (8) begin
            if (vld[1]) seen = 1;
            step();
        end
        chk("no_rsp_after_rst", 1, 32'(seen), 0);
        xact(1, 1'b0, 32'h40, 3'd2, 32'h0, 0, d, e, l);
        chk("lw40_kept", 1, d, 32'hCAFEF00D);

        for (int n = 0; n < 150; n++) begin
            for (int k = 0; k < 2; k++) begin
                we = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0)
                    f3 = 3'($urandom_range(0, 7));
                else if (we)
                    f3 = 3'($urandom_range(0, 2));
                else
                    f3 = lld[$urandom_range(0, 4)];
                case ($urandom_range(0, 7))
                    0:       a = 32'(4 * DEPTH) + $urandom_range(0, 15);
                    1:       a = $urandom;
                    default: a = $urandom_range(0, 4 * DEPTH - 1);
                endcase
                if ($urandom_range(0, 2) != 0) begin
                    if (f3[1:0] == 2'd1) a[0] = 1'b0;
                    if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
                end
                xact(k, we, a, f3, $urandom,
                     $urandom_range(0, 3), d, e, l);
            end
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
